mem_port_arbiter: RTL

- Shares one unified single-port memory between the CPU instruction-fetch port and the load/store data port.
- Grants one requester at a time, sequences a fixed-latency memory access, and returns the read data (or write completion) to the owning requester.
- The CPU stalls on missing grant/valid.
- Sits between the CPU's instruction/data address outputs and the memory macro.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data ports.
// Grants in IDLE only, waits a fixed MEM_LAT cycles, returns data to the owner.
module mem_port_arbiter #(
   parameter int nbit    = 32,
   parameter int MEM_LAT = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [nbit-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [nbit-1:0] if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [nbit-1:0] d_addr,
   input  logic [nbit-1:0] d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [nbit-1:0] d_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [nbit-1:0] mem_addr,
   output logic [nbit-1:0] mem_wdata,
   input  logic [nbit-1:0] mem_rdata,
   output logic            busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic       OWN_IF = 1'b0;
   localparam logic       OWN_D  = 1'b1;
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic       we_q, we_d;
   logic       last_q, last_d;
   logic       sel_if, sel_d;
   logic       done;

   // Same-cycle grant; on a tie the port that did not win last time goes first.
   always_comb begin
      sel_if = 1'b0;
      sel_d  = 1'b0;
      if (state_q == IDLE && !reset) begin
         if (if_req && d_req) begin
            if (last_q == OWN_D) sel_if = 1'b1;
            else                 sel_d  = 1'b1;
         end else if (if_req) begin
            sel_if = 1'b1;
         end else if (d_req) begin
            sel_d = 1'b1;
         end
      end
   end

   assign if_gnt    = sel_if;
   assign d_gnt     = sel_d;
   assign mem_en    = sel_if | sel_d;
   assign mem_we    = sel_d & d_we;
   assign mem_addr  = sel_d ? d_addr : (sel_if ? if_addr : '0);
   assign mem_wdata = sel_d ? d_wdata : '0;

   assign done      = (state_q == BUSY) && (cnt_q == 4'd0);
   assign if_rvalid = done && (owner_q == OWN_IF);
   assign d_rvalid  = done && (owner_q == OWN_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
   assign busy      = (state_q == BUSY);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      we_d    = we_q;
      last_d  = last_q;
      if (state_q == IDLE) begin
         if (mem_en) begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
            owner_d = sel_d;
            we_d    = mem_we;
            last_d  = sel_d;
         end
      end else begin
         if (cnt_q == 4'd0) state_d = IDLE;
         else               cnt_d   = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         last_q  <= OWN_D;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         last_q  <= last_d;
      end
   end

endmodule
